// File: rtl/clk_mgm_pkg.sv
// Shared types, default widths and helpers for the N-phase Razor clock manager.
package clk_mgm_pkg;

    localparam int unsigned DEF_NUM_PHASES   = 2;
    localparam int unsigned DEF_STALL_CYCLES = 1;
    localparam int unsigned DEF_ERR_CNT_W    = 16;
    localparam int unsigned DEF_ERR_LIMIT    = 255;
    localparam int unsigned MAX_PHASES       = 32;

    typedef enum logic [0:0] {
        ST_RUN,
        ST_STALL
    } clk_mgm_state_e;

    // OR-reduction encoder; valid only for a one-hot input.
    function automatic int unsigned onehot_to_idx(input logic [MAX_PHASES-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_PHASES; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/clk_mgm_gate_cell.sv
// Latch-based clock gate: low-transparent enable latch ANDed with the clock.
// Kept as its own cell so it can be swapped for a library ICG.
module clk_mgm_gate_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic gclk
);

    logic en_lat;

    always_latch begin
        if (rst) begin
            en_lat <= 1'b0;
        end else if (!clk) begin
            en_lat <= en;
        end
    end

    assign gclk = clk & en_lat;

endmodule

// File: rtl/clk_mgm_razor_nphase.sv
// N-phase clock manager for Razor pipelines: one-hot phase ring that holds on errors.
// Optional error limit with sticky Fatal output when CLK_MGM_ERR_LIMIT_EN is defined.
module clk_mgm_razor_nphase
    import clk_mgm_pkg::*;
#(
    parameter int unsigned NUM_PHASES   = DEF_NUM_PHASES,
    parameter int unsigned STALL_CYCLES = DEF_STALL_CYCLES,
    parameter int unsigned ERR_CNT_W    = DEF_ERR_CNT_W
`ifdef CLK_MGM_ERR_LIMIT_EN
    ,
    parameter int unsigned ERR_LIMIT    = DEF_ERR_LIMIT
`endif
) (
    input  logic                          Clock_Sys,
    input  logic                          Reset,
    input  logic                          GlobalError,
    input  logic                          Enable,
    output logic [NUM_PHASES-1:0]         Clock_Phase,
    output logic [NUM_PHASES-1:0]         Phase_En,
    output logic [$clog2(NUM_PHASES)-1:0] Phase_Idx,
    output logic                          Stall,
    output logic [ERR_CNT_W-1:0]          ErrorCount
`ifdef CLK_MGM_ERR_LIMIT_EN
    ,
    output logic                          Fatal
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_PHASES);
    localparam int unsigned CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STALL_CYCLES - 1);

    logic [NUM_PHASES-1:0] phase_q, phase_d;
    clk_mgm_state_e        state_q, state_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic                  halted;
    logic                  active;

    assign active = Enable && !halted;

    always_ff @(posedge Clock_Sys or posedge Reset) begin
        if (Reset) begin
            phase_q     <= NUM_PHASES'(1);
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            phase_q     <= phase_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // The erroring edge itself is the first hold edge; STALL covers the remaining ones.
    always_comb begin
        phase_d     = phase_q;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (active) begin
            if (GlobalError && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            unique case (state_q)
                ST_RUN: begin
                    if (!GlobalError) begin
                        phase_d = {phase_q[NUM_PHASES-2:0], phase_q[NUM_PHASES-1]};
                    end else if (STALL_CYCLES > 1) begin
                        state_d     = ST_STALL;
                        stall_cnt_d = RELOAD;
                    end
                end
                ST_STALL: begin
                    if (GlobalError) begin
                        stall_cnt_d = RELOAD;
                    end else begin
                        stall_cnt_d = stall_cnt_q - CNT_W'(1);
                        if (stall_cnt_q == CNT_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            endcase
        end
    end

`ifdef CLK_MGM_ERR_LIMIT_EN
    logic fatal_q, fatal_d;

    always_ff @(posedge Clock_Sys or posedge Reset) begin
        if (Reset) begin
            fatal_q <= 1'b0;
        end else begin
            fatal_q <= fatal_d;
        end
    end

    always_comb begin
        fatal_d = fatal_q;
        if ((err_cnt_d != err_cnt_q) && (err_cnt_d == ERR_CNT_W'(ERR_LIMIT))) begin
            fatal_d = 1'b1;
        end
    end

    assign halted = fatal_q;
    assign Fatal  = fatal_q;
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        Phase_En   = active ? phase_q : '0;
        Phase_Idx  = IDX_W'(onehot_to_idx(MAX_PHASES'(phase_q)));
        Stall      = (state_q == ST_STALL);
        ErrorCount = err_cnt_q;
    end

    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_gate
        clk_mgm_gate_cell u_gate (
            .clk  (Clock_Sys),
            .rst  (Reset),
            .en   (Phase_En[g]),
            .gclk (Clock_Phase[g])
        );
    end

endmodule

// File: tb/tb_clk_mgm_razor_nphase.sv
// Randomized self-checking bench for clk_mgm_razor_nphase against a hold-counter model.
module tb_clk_mgm_razor_nphase;

    localparam int unsigned NP   = 4;
    localparam int unsigned SC   = 3;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic            Clock_Sys = 1'b0;
    logic            Reset;
    logic            GlobalError;
    logic            Enable;
    logic [NP-1:0]   Clock_Phase;
    logic [NP-1:0]   Phase_En;
    logic [1:0]      Phase_Idx;
    logic            Stall;
    logic [CW-1:0]   ErrorCount;
`ifdef CLK_MGM_ERR_LIMIT_EN
    logic            fatal;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: current phase number, edges of hold still owed, error tally.
    int m_idx;
    int m_hold;
    int m_cnt;

    clk_mgm_razor_nphase #(
        .NUM_PHASES   (NP),
        .STALL_CYCLES (SC),
        .ERR_CNT_W    (CW)
    ) dut (
        .Clock_Sys   (Clock_Sys),
        .Reset       (Reset),
        .GlobalError (GlobalError),
        .Enable      (Enable),
        .Clock_Phase (Clock_Phase),
        .Phase_En    (Phase_En),
        .Phase_Idx   (Phase_Idx),
        .Stall       (Stall),
        .ErrorCount  (ErrorCount)
`ifdef CLK_MGM_ERR_LIMIT_EN
        ,
        .Fatal       (fatal)
`endif
    );

    always #5 Clock_Sys = ~Clock_Sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] onehot(input int idx);
        logic [NP-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_idx  = 0;
        m_hold = 0;
        m_cnt  = 0;
    endtask

    task automatic model_edge(input logic err, input logic en);
        if (en) begin
            if (err) begin
                m_cnt  = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                m_hold = SC - 1;
            end else if (m_hold > 0) begin
                m_hold--;
            end else begin
                m_idx = (m_idx + 1) % NP;
            end
        end
    endtask

    task automatic check_state();
        check("phase_idx", 32'(Phase_Idx), 32'(m_idx));
        check("stall", 32'(Stall), 32'(m_hold > 0));
        check("error_count", 32'(ErrorCount), 32'(m_cnt));
`ifdef CLK_MGM_ERR_LIMIT_EN
        check("fatal", 32'(fatal), 32'd0);
`endif
    endtask

    // Called with the clock low; drives one cycle and checks it end to end.
    task automatic step(input logic err, input logic en);
        logic [NP-1:0] exp_gate;
        GlobalError = err;
        Enable      = en;
        #1;
        exp_gate = en ? onehot(m_idx) : '0;
        check("phase_en", 32'(Phase_En), 32'(exp_gate));
        @(posedge Clock_Sys);
        #1;
        check("clock_phase_high", 32'(Clock_Phase), 32'(exp_gate));
        model_edge(err, en);
        @(negedge Clock_Sys);
        #1;
        check("clock_phase_low", 32'(Clock_Phase), 32'd0);
        check_state();
    endtask

    // Async reset asserted while the clock is high, away from any edge.
    task automatic reset_mid();
        GlobalError = 1'b1;
        Enable      = 1'b1;
        @(posedge Clock_Sys);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check("rst_clock_phase", 32'(Clock_Phase), 32'd0);
        check("rst_phase_en", 32'(Phase_En), 32'(onehot(0)));
        check_state();
        @(negedge Clock_Sys);
        Reset = 1'b0;
        #1;
    endtask

    initial begin
        Reset       = 1'b1;
        Enable      = 1'b0;
        GlobalError = 1'b0;
        model_reset();
        repeat (2) @(negedge Clock_Sys);
        #1;
        check_state();
        check("reset_phase_en_off", 32'(Phase_En), 32'd0);
        @(posedge Clock_Sys);
        #1;
        check("reset_clock_phase", 32'(Clock_Phase), 32'd0);
        @(negedge Clock_Sys);
        Enable = 1'b1;
        #1;
        check("reset_phase_en_on", 32'(Phase_En), 32'(onehot(0)));
        Reset = 1'b0;
        #1;

        // Plain rotation.
        repeat (7) step(1'b0, 1'b1);

        // Error at phase 2 followed by a second error inside the stall window.
        for (int i = 0; i < NP && m_idx != 2; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);

        // Frozen ring ignores errors.
        for (int i = 0; i < NP && m_idx != 1; i++) step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1);

        // Enable dropped mid-stall, then stall resumes.
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1);

        // Saturation, then async reset in the middle of an error stream.
        repeat (20) step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b1);
        reset_mid();
        repeat (3) step(1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                reset_mid();
            end
            step(($urandom_range(0, 4) == 0), ($urandom_range(0, 6) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_mgm_razor_nphase.md
Name: clk_mgm_razor_nphase

Overview:
Parametrised N-phase clock manager for Razor-style pipelines: rotates a one-hot phase ring on Clock_Sys and produces glitch-free gated phase clocks.
On GlobalError the ring holds its current phase for STALL_CYCLES edges, so the erroneous stage is replayed.
Adds enable/freeze, a saturating error counter and a stall indicator.
Sits between the system clock root and the Razor stage clock pins.

Parameters:
NUM_PHASES, 2, number of phase clocks in the ring (>=2).
STALL_CYCLES, 1, Clock_Sys edges the ring holds per error (>=1).
ERR_CNT_W, 16, width of saturating error counter.

Ports:
Clock_Sys  input  1  system clock; the only clock.
Reset  input  1  asynchronous, active-high reset.
GlobalError  input  1  OR of Razor stage errors; sampled on Clock_Sys rising edge.
Enable  input  1  1 = ring runs; 0 = ring frozen and all phase clocks gated off.
Clock_Phase  output  NUM_PHASES  gated phase clocks.
Phase_En  output  NUM_PHASES  one-hot phase enable before gating.
Phase_Idx  output  $clog2(NUM_PHASES)  binary index of the active phase.
Stall  output  1  high while the ring is in STALL.
ErrorCount  output  ERR_CNT_W  saturating count of sampled errors.

Behaviour:
- Reset (async, active-high):
  - phase_q=one-hot bit0; Phase_Idx=0; state=RUN; stall_cnt=0; ErrorCount=0; Stall=0.
  - Gating latches cleared, so Clock_Phase=0.
- Phase_En = phase_q when Enable=1, else all zeros. Combinational from registered state.
- Clock_Phase[i] = Clock_Sys AND en_lat[i].
  - en_lat[i] is transparent while Clock_Sys is low and captures Phase_En[i].
  - No glitches; a gating change takes effect on the next high phase.
- Every rising edge with Enable=1 and GlobalError=1:
  - ErrorCount increments and saturates at all-ones.
- FSM, evaluated only when Enable=1. Enable=0 freezes phase_q, state and stall_cnt. Errors are not counted while Enable=0.
  - RUN, GlobalError=0: phase_q rotates left by one (bit NUM_PHASES-1 wraps to bit0); Phase_Idx increments modulo NUM_PHASES.
  - RUN, GlobalError=1: phase_q holds. This hold is the first stall edge.
    - STALL_CYCLES=1: stay in RUN.
    - STALL_CYCLES>1: go to STALL with stall_cnt=STALL_CYCLES-1.
  - STALL, GlobalError=1: phase_q holds; stall_cnt reloads to STALL_CYCLES-1.
  - STALL, GlobalError=0: phase_q holds; stall_cnt decrements. When stall_cnt goes 1->0, go to RUN; rotation resumes on the following edge.
- Total hold per isolated error = exactly STALL_CYCLES edges.
- With NUM_PHASES=2 and STALL_CYCLES=1, the outputs are cycle-equivalent to the existing even/odd Razor divider.
- Stall = (state==STALL). Registered; asserts the edge after the error.
- Reset mid-stall: returns to RUN at phase 0 immediately.
- Enable deasserted mid-stall: stall resumes with the remaining count when Enable returns.

Optional Feature:
Macro: CLK_MGM_ERR_LIMIT_EN.

Defined:
- Adds parameter ERR_LIMIT (default 255) and output Fatal (1 bit, reset 0).
- Fatal sets sticky on the edge at which ErrorCount reaches ERR_LIMIT.
- While Fatal=1: Phase_En=0, all Clock_Phase gated low, FSM frozen.
- Only Reset clears Fatal.

Undefined:
- No Fatal port; no limit; counter only saturates.

Decomposition:
- Package clk_mgm_pkg:
  - FSM state enum (ST_RUN, ST_STALL).
  - Function for one-hot to binary index.
  - Default-width constants.
- One sub-module, clk_mgm_gate_cell:
  - Latch-based ICG: low-transparent enable latch plus AND, async clear on Reset.
  - Instantiated NUM_PHASES times via generate.
  - Isolates the technology ICG for later swap to a library cell.

Test Plan:
1. NUM_PHASES=3, STALL_CYCLES=1, no errors, 7 edges after reset release -> Phase_Idx 0,1,2,0,1,2,0. Exactly one Clock_Phase pulses per Clock_Sys cycle. No overlap, no glitch.
2. NUM_PHASES=2, STALL_CYCLES=1, GlobalError=1 for one edge at Phase_Idx=1 -> Phase_Idx sequence 1,1,0. ErrorCount=1. Stall stays 0.
3. NUM_PHASES=4, STALL_CYCLES=3, error at Phase_Idx=2, then a second error 1 edge later (during STALL) -> stall_cnt reloads. Phase_Idx holds 2 for 4 edges, then 3. Stall high for 3 edges. ErrorCount=2.
4. Enable=0 for 5 edges during RUN at Phase_Idx=1, with GlobalError=1 asserted meanwhile -> all Clock_Phase low, Phase_Idx stays 1, ErrorCount unchanged. After Enable=1, rotation resumes 2,3,...
5. ERR_CNT_W=4, 20 consecutive error edges -> ErrorCount saturates at 15. Phase stays held throughout. Reset asserted mid-stream -> all outputs return to reset values asynchronously.
6. CLK_MGM_ERR_LIMIT_EN defined, ERR_LIMIT=3, three isolated errors -> Fatal=1 on the 3rd counted error edge. Phase_En=0 and Clock_Phase silent until Reset.
